mem_bus_arbiter: RTL and testbench

- Shares one single-port synchronous memory between the CPU instruction-fetch port and data-memory port, giving a unified instruction/data memory.
- Sits between openmips and the memory inside the SOPC, replacing the direct inst_rom connection.
- Sequences each access over a fixed wait-state count and returns a one-cycle ack per request.
- Raises a stall request to the pipeline controller while any request is pending.

---
 rtl/mem_bus_arbiter_pkg.sv | 28 ++
 rtl/arb_wait_counter.sv | 30 +++
 rtl/mem_bus_arbiter.sv | 155 +++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types for the unified instruction/data memory arbiter.
// Owner/state encodings, bus widths and the saturating streak helper.
package mem_bus_arbiter_pkg;

  localparam int MEM_ADDR_W = 32;
  localparam int MEM_DATA_W = 32;
  localparam int MEM_SEL_W  = 4;
  localparam int CNT_W      = 4;

  localparam logic [MEM_SEL_W-1:0] SEL_ALL = '1;

  typedef enum logic {
    OWNER_IF = 1'b0,
    OWNER_DM = 1'b1
  } owner_e;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_ACCESS = 2'd1,
    ARB_RESP   = 2'd2
  } arb_state_e;

  // Saturates so a long data burst can never wrap the streak back below the limit.
  function automatic logic [CNT_W-1:0] streak_next(input logic [CNT_W-1:0] s);
    return (s == '1) ? s : s + 1'b1;
  endfunction

endpackage

// File: rtl/arb_wait_counter.sv
// Loadable down-counter with a zero flag; load wins over decrement.
// Stops at zero, so a stray decrement cannot wrap.
module arb_wait_counter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic         o_zero
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one single-port synchronous memory between instruction fetch and data ports.
// Fixed wait-state access, one-cycle ack per request, data priority with fetch anti-starvation.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int WAIT_CYCLES  = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req_i,
  input  logic [MEM_ADDR_W-1:0] if_addr_i,
  output logic [MEM_DATA_W-1:0] if_rdata_o,
  output logic                  if_ack_o,
  input  logic                  dm_req_i,
  input  logic                  dm_we_i,
  input  logic [MEM_SEL_W-1:0]  dm_sel_i,
  input  logic [MEM_ADDR_W-1:0] dm_addr_i,
  input  logic [MEM_DATA_W-1:0] dm_wdata_i,
  output logic [MEM_DATA_W-1:0] dm_rdata_o,
  output logic                  dm_ack_o,
  output logic                  mem_ce_o,
  output logic                  mem_we_o,
  output logic [MEM_SEL_W-1:0]  mem_sel_o,
  output logic [MEM_ADDR_W-1:0] mem_addr_o,
  output logic [MEM_DATA_W-1:0] mem_wdata_o,
  input  logic [MEM_DATA_W-1:0] mem_rdata_i,
  output logic                  stall_req_o
);

  arb_state_e            r_state;
  arb_state_e            w_state_nxt;
  owner_e                r_owner;
  logic                  r_we;
  logic [MEM_SEL_W-1:0]  r_sel;
  logic [MEM_ADDR_W-1:0] r_addr;
  logic [MEM_DATA_W-1:0] r_wdata;
  logic [MEM_DATA_W-1:0] r_if_rdata;
  logic [MEM_DATA_W-1:0] r_dm_rdata;
  logic [CNT_W-1:0]      r_streak;

  logic w_in_resp;
  logic w_if_elig;
  logic w_dm_elig;
  logic w_starved;
  logic w_grant_if;
  logic w_grant_dm;
  logic w_take;
  logic w_cnt_dec;
  logic w_cnt_zero;
  logic w_capture;

  // The requester being acked this cycle is masked so the other port can follow with no gap.
  assign w_in_resp  = (r_state == ARB_RESP);
  assign w_if_elig  = if_req_i & ~(w_in_resp & (r_owner == OWNER_IF));
  assign w_dm_elig  = dm_req_i & ~(w_in_resp & (r_owner == OWNER_DM));
  assign w_starved  = (r_streak >= CNT_W'(STARVE_LIMIT));
  assign w_grant_if = w_if_elig & (~w_dm_elig | w_starved);
  assign w_grant_dm = w_dm_elig & ~w_grant_if;

  arb_wait_counter #(.W(CNT_W)) u_wait_cnt (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_take),
    .i_load_val (CNT_W'(WAIT_CYCLES - 1)),
    .i_dec      (w_cnt_dec),
    .o_zero     (w_cnt_zero)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ARB_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_take      = 1'b0;
    w_cnt_dec   = 1'b0;
    w_capture   = 1'b0;
    unique case (r_state)
      ARB_IDLE: begin
        if (w_grant_if || w_grant_dm) begin
          w_take      = 1'b1;
          w_state_nxt = ARB_ACCESS;
        end
      end
      ARB_ACCESS: begin
        if (w_cnt_zero) begin
          w_capture   = 1'b1;
          w_state_nxt = ARB_RESP;
        end else begin
          w_cnt_dec = 1'b1;
        end
      end
      ARB_RESP: begin
        if (w_grant_if || w_grant_dm) begin
          w_take      = 1'b1;
          w_state_nxt = ARB_ACCESS;
        end else begin
          w_state_nxt = ARB_IDLE;
        end
      end
      default: w_state_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_owner    <= OWNER_IF;
      r_we       <= 1'b0;
      r_sel      <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_streak   <= '0;
      r_if_rdata <= '0;
      r_dm_rdata <= '0;
    end else begin
      if (w_take) begin
        r_owner <= w_grant_dm ? OWNER_DM : OWNER_IF;
        r_we    <= w_grant_dm & dm_we_i;
        r_sel   <= w_grant_dm ? dm_sel_i : SEL_ALL;
        r_addr  <= w_grant_dm ? dm_addr_i : if_addr_i;
        r_wdata <= w_grant_dm ? dm_wdata_i : '0;
        if (w_grant_dm && if_req_i) begin
          r_streak <= streak_next(r_streak);
        end else begin
          r_streak <= '0;
        end
      end
      if (w_capture) begin
        if (r_owner == OWNER_IF) begin
          r_if_rdata <= mem_rdata_i;
        end else if (!r_we) begin
          r_dm_rdata <= mem_rdata_i;
        end
      end
    end
  end

  assign mem_ce_o    = (r_state == ARB_ACCESS);
  assign mem_we_o    = mem_ce_o & r_we;
  assign mem_sel_o   = r_sel;
  assign mem_addr_o  = r_addr;
  assign mem_wdata_o = r_wdata;

  assign if_ack_o    = w_in_resp & (r_owner == OWNER_IF);
  assign dm_ack_o    = w_in_resp & (r_owner == OWNER_DM);
  assign if_rdata_o  = r_if_rdata;
  assign dm_rdata_o  = r_dm_rdata;
  assign stall_req_o = (if_req_i & ~if_ack_o) | (dm_req_i & ~dm_ack_o);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: stimulus pushes expected acks, a monitor pops them.
// Runs with WAIT_CYCLES=2 and STARVE_LIMIT=1 so the forced-fetch path is reachable.
module tb_mem_bus_arbiter;

  localparam int W = 2;

  logic        clk;
  logic        rst;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic [31:0] if_rdata_o;
  logic        if_ack_o;
  logic        dm_req_i;
  logic        dm_we_i;
  logic [3:0]  dm_sel_i;
  logic [31:0] dm_addr_i;
  logic [31:0] dm_wdata_i;
  logic [31:0] dm_rdata_o;
  logic        dm_ack_o;
  logic        mem_ce_o;
  logic        mem_we_o;
  logic [3:0]  mem_sel_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i;
  logic        stall_req_o;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    bit          is_dm;
    logic [31:0] data;
    int          cyc;
  } exp_t;
  exp_t sb[$];

  mem_bus_arbiter #(.WAIT_CYCLES(W), .STARVE_LIMIT(1)) dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_rdata_o(if_rdata_o), .if_ack_o(if_ack_o),
    .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_sel_i(dm_sel_i), .dm_addr_i(dm_addr_i),
    .dm_wdata_i(dm_wdata_i), .dm_rdata_o(dm_rdata_o), .dm_ack_o(dm_ack_o),
    .mem_ce_o(mem_ce_o), .mem_we_o(mem_we_o), .mem_sel_o(mem_sel_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .stall_req_o(stall_req_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] rd_of(input logic [31:0] a);
    case (a)
      32'h10:  return 32'h34011100;
      32'h20:  return 32'h11223344;
      32'h24:  return 32'h55667788;
      32'h30:  return 32'hCAFEF00D;
      32'h44:  return 32'h0BADF00D;
      default: return a ^ 32'hA5A5A5A5;
    endcase
  endfunction

  assign mem_rdata_i = mem_ce_o ? rd_of(mem_addr_o) : 32'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input bit is_dm, input logic [31:0] data, input int c);
    sb.push_back('{is_dm, data, c});
  endtask

  // Monitor: every ack must match the next scoreboard entry in owner, cycle and data.
  always @(negedge clk) begin
    exp_t e;
    if (if_ack_o && dm_ack_o) begin
      checks++; errors++;
      $display("FAIL dual_ack: both acks high at cyc %0d", cyc);
    end else if (if_ack_o || dm_ack_o) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_ack: if=%0b dm=%0b at cyc %0d", if_ack_o, dm_ack_o, cyc);
      end else begin
        e = sb.pop_front();
        chk("ack_owner_dm", {31'd0, dm_ack_o}, {31'd0, e.is_dm});
        chk("ack_cycle", cyc, e.cyc);
        if (e.is_dm) chk("dm_rdata", dm_rdata_o, e.data);
        else         chk("if_rdata", if_rdata_o, e.data);
      end
    end
  end

  // Holds requests through the ack cycle and drops them just after the edge that ends it.
  task automatic wait_acks(input int n, input bit chk_cmd, input logic we_e,
                           input logic [3:0] sel_e, input logic [31:0] addr_e,
                           input logic [31:0] wdata_e, output int ce_cnt, output logic stall_at_ack);
    int got = 0;
    bit drop_if = 0;
    bit drop_dm = 0;
    ce_cnt = 0;
    stall_at_ack = 1'b0;
    for (int i = 0; i < 50 && got < n; i++) begin
      @(posedge clk); #1;
      if (drop_if) if_req_i = 1'b0;
      if (drop_dm) dm_req_i = 1'b0;
      drop_if = 0; drop_dm = 0;
      @(negedge clk);
      if (mem_ce_o) begin
        ce_cnt++;
        if (chk_cmd) begin
          chk("cmd_we", {31'd0, mem_we_o}, {31'd0, we_e});
          chk("cmd_sel", {28'd0, mem_sel_o}, {28'd0, sel_e});
          chk("cmd_addr", mem_addr_o, addr_e);
          chk("cmd_wdata", mem_wdata_o, wdata_e);
        end
      end else begin
        chk("we_without_ce", {31'd0, mem_we_o}, 32'd0);
      end
      if (if_ack_o || dm_ack_o) begin
        got++;
        stall_at_ack = stall_req_o;
      end
      if (if_ack_o) drop_if = 1;
      if (dm_ack_o) drop_dm = 1;
    end
    if (got < n) begin
      checks++; errors++;
      $display("FAIL ack_timeout: got %0d acks expected %0d", got, n);
    end
    @(posedge clk); #1;
    if (drop_if) if_req_i = 1'b0;
    if (drop_dm) dm_req_i = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    int ce;
    logic st;
    rst = 1'b0;
    if_req_i = 1'b0; if_addr_i = '0;
    dm_req_i = 1'b0; dm_we_i = 1'b0; dm_sel_i = '0; dm_addr_i = '0; dm_wdata_i = '0;
    repeat (2) @(negedge clk);
    chk("rst_ce", {31'd0, mem_ce_o}, 32'd0);
    chk("rst_we", {31'd0, mem_we_o}, 32'd0);
    chk("rst_sel", {28'd0, mem_sel_o}, 32'd0);
    chk("rst_addr", mem_addr_o, 32'd0);
    chk("rst_wdata", mem_wdata_o, 32'd0);
    chk("rst_if_rdata", if_rdata_o, 32'd0);
    chk("rst_dm_rdata", dm_rdata_o, 32'd0);
    chk("rst_acks", {30'd0, if_ack_o, dm_ack_o}, 32'd0);
    chk("rst_stall", {31'd0, stall_req_o}, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // Reset during the second ACCESS cycle abandons the fetch with no ack.
    if_req_i = 1'b1; if_addr_i = 32'h44;
    @(negedge clk);
    chk("abort_ce_before", {31'd0, mem_ce_o}, 32'd1);
    @(negedge clk);
    rst = 1'b0; #1;
    chk("abort_ce_now", {31'd0, mem_ce_o}, 32'd0);
    if_req_i = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    chk("abort_if_rdata", if_rdata_o, 32'd0);
    chk("abort_stall", {31'd0, stall_req_o}, 32'd0);

    // Single fetch.
    c = cyc;
    push(1'b0, 32'h34011100, c + 1 + W);
    if_req_i = 1'b1; if_addr_i = 32'h10; #1;
    chk("fetch_stall_req", {31'd0, stall_req_o}, 32'd1);
    wait_acks(1, 1'b1, 1'b0, 4'hF, 32'h10, 32'h0, ce, st);
    chk("fetch_ce_cycles", ce, W);
    chk("fetch_stall_at_ack", {31'd0, st}, 32'd0);
    repeat (2) @(negedge clk);
    chk("fetch_rdata_held", if_rdata_o, 32'h34011100);

    // Simultaneous requests: data first, fetch follows with no idle gap.
    c = cyc;
    push(1'b1, 32'h11223344, c + 1 + W);
    push(1'b0, 32'hCAFEF00D, c + 2 + 2 * W);
    if_req_i = 1'b1; if_addr_i = 32'h30;
    dm_req_i = 1'b1; dm_we_i = 1'b0; dm_sel_i = 4'hF; dm_addr_i = 32'h20;
    wait_acks(2, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, ce, st);
    chk("both_ce_cycles", ce, 2 * W);

    // Data write: read-data register must not move.
    c = cyc;
    push(1'b1, 32'h11223344, c + 1 + W);
    dm_req_i = 1'b1; dm_we_i = 1'b1; dm_sel_i = 4'b0011;
    dm_addr_i = 32'h80; dm_wdata_i = 32'hDEADBEEF;
    wait_acks(1, 1'b1, 1'b1, 4'b0011, 32'h80, 32'hDEADBEEF, ce, st);
    chk("write_ce_cycles", ce, W);
    dm_we_i = 1'b0; dm_sel_i = 4'hF; dm_wdata_i = '0;

    // Request dropped after grant still completes and acks.
    c = cyc;
    push(1'b1, 32'h55667788, c + 1 + W);
    dm_req_i = 1'b1; dm_addr_i = 32'h24;
    @(negedge clk);
    dm_req_i = 1'b0; #1;
    chk("drop_stall_access", {31'd0, stall_req_o}, 32'd0);
    wait_acks(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, ce, st);
    chk("drop_stall_at_ack", {31'd0, st}, 32'd0);

    // Data granted while fetch still asserted in its ack cycle builds a streak of 1.
    c = cyc;
    push(1'b0, 32'h34011100, c + 1 + W);
    push(1'b1, 32'h11223344, c + 2 + 2 * W);
    if_req_i = 1'b1; if_addr_i = 32'h10;
    @(negedge clk);
    dm_req_i = 1'b1; dm_addr_i = 32'h20;
    wait_acks(2, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, ce, st);

    // Streak at limit: fetch wins a simultaneous request.
    c = cyc;
    push(1'b0, 32'hCAFEF00D, c + 1 + W);
    push(1'b1, 32'h55667788, c + 2 + 2 * W);
    if_req_i = 1'b1; if_addr_i = 32'h30;
    dm_req_i = 1'b1; dm_addr_i = 32'h24;
    wait_acks(2, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, ce, st);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 32'd0);
    chk("final_stall", {31'd0, stall_req_o}, 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
